float_mul_pipeline: RTL and testbench

Pipelined IEEE-754 single-precision floating-point multiplier with a req/ack handshake. It is the multiply unit behind the GPU core's floating-point datapath. It takes two operands, runs them through a fixed six-stage pipeline, and presents the product with a one-cycle ack pulse. Only one operation is in flight at a time.

---
 rtl/float_pkg.sv | 31 +++
 rtl/float_mul_pipeline_mant_mul.sv | 31 +++
 rtl/float_mul_pipeline.sv | 155 +++++++++++++++
 tb/tb_float_mul_pipeline.sv | 129 ++++++++++++
 4 files changed

// File: rtl/float_pkg.sv
// Shared types and constants for the binary32 multiply pipeline.
package float_pkg;

    localparam int FLOAT_WIDTH = 32;
    localparam int EXP_WIDTH   = 8;
    localparam int FRAC_WIDTH  = 23;
    localparam int EXP_BIAS    = 127;
    localparam int EXP_MAX     = 255;
    localparam logic [FLOAT_WIDTH-1:0] QNAN = 32'h7FC00000;

    typedef struct packed {
        logic                  sign;
        logic [EXP_WIDTH-1:0]  exp;
        logic [FRAC_WIDTH-1:0] frac;
    } float32_t;

    typedef enum logic {IDLE, BUSY} state_e;

    // Result class decided early so later stages only carry two bits of special-case state.
    typedef enum logic [1:0] {CLS_NORM, CLS_ZERO, CLS_INF, CLS_NAN} cls_e;

    // {zero, inf, nan}; a zero exponent (subnormal included) counts as zero.
    function automatic logic [2:0] classify(input float32_t f);
        logic exp_zero, exp_ones, frac_zero;
        exp_zero  = (f.exp == '0);
        exp_ones  = (f.exp == '1);
        frac_zero = (f.frac == '0);
        return {exp_zero, exp_ones && frac_zero, exp_ones && !frac_zero};
    endfunction

endpackage

// File: rtl/float_mul_pipeline_mant_mul.sv
// Two-cycle 24x24 -> 48 unsigned multiply: partial products, then their sum.
module mant_mul_24 (
    input  logic        clk,
    input  logic        rst,
    input  logic [23:0] a_i,
    input  logic [23:0] b_i,
    output logic [47:0] p_o
);

    logic [35:0] pp_lo_d, pp_hi_d, pp_lo_q, pp_hi_q;
    logic [47:0] p_d, p_q;

    assign pp_lo_d = {12'b0, a_i} * {24'b0, b_i[11:0]};
    assign pp_hi_d = {12'b0, a_i} * {24'b0, b_i[23:12]};
    assign p_d     = {pp_hi_q, 12'b0} + {12'b0, pp_lo_q};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pp_lo_q <= '0;
            pp_hi_q <= '0;
            p_q     <= '0;
        end else begin
            pp_lo_q <= pp_lo_d;
            pp_hi_q <= pp_hi_d;
            p_q     <= p_d;
        end
    end

    assign p_o = p_q;

endmodule

// File: rtl/float_mul_pipeline.sv
// Six-stage binary32 multiplier with req/ack handshake, one operation in flight.
// FLOAT_MUL_RNE_EN selects round-to-nearest-even; otherwise the result is truncated.
module float_mul_pipeline
    import float_pkg::*;
#(
    parameter int float_width = FLOAT_WIDTH
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   req,
    output logic                   ack,
    input  logic [float_width-1:0] a,
    input  logic [float_width-1:0] b,
    output logic [float_width-1:0] out
);

    state_e     state_q, state_d;
    logic       accept;
    logic [5:0] vld_q;
    logic       ack_q;
    logic [31:0] out_q, out_d;

    float32_t   a_q, b_q;
    float32_t   fa1_q, fb1_q;
    logic [2:0] ca1_q, cb1_q;

    logic              s2_q, s3_q, s4_q, s5_q;
    logic signed [9:0] e2_d, e2_q, e3_q, e4_q, e5_d, e5_q;
    cls_e              c2_d, c2_q, c3_q, c4_q, c5_q;
    logic [23:0]       ma2_q, mb2_q, m5_d, m5_q;
    logic [47:0]       prod;
    logic [23:0]       disc;
    logic [2:0]        grs5_d, grs5_q;

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        case (state_q)
            IDLE: if (req) begin
                accept  = 1'b1;
                state_d = BUSY;
            end
            BUSY: if (vld_q[5]) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            vld_q   <= '0;
            ack_q   <= 1'b0;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            vld_q   <= {vld_q[4:0], accept};
            ack_q   <= vld_q[5];
            if (vld_q[5]) out_q <= out_d;
        end
    end

    // Datapath registers need no reset: only vld_q qualifies them.
    always_ff @(posedge clk) begin
        if (accept) begin
            a_q <= float32_t'(a);
            b_q <= float32_t'(b);
        end
        fa1_q <= a_q;
        fb1_q <= b_q;
        ca1_q <= classify(a_q);
        cb1_q <= classify(b_q);
        s2_q  <= fa1_q.sign ^ fb1_q.sign;
        e2_q  <= e2_d;
        c2_q  <= c2_d;
        ma2_q <= {1'b1, fa1_q.frac};
        mb2_q <= {1'b1, fb1_q.frac};
        {s3_q, e3_q, c3_q} <= {s2_q, e2_q, c2_q};
        {s4_q, e4_q, c4_q} <= {s3_q, e3_q, c3_q};
        s5_q   <= s4_q;
        e5_q   <= e5_d;
        c5_q   <= c4_q;
        m5_q   <= m5_d;
        grs5_q <= grs5_d;
    end

    // ca/cb bit order is {zero, inf, nan}.
    always_comb begin
        e2_d = $signed({2'b0, fa1_q.exp}) + $signed({2'b0, fb1_q.exp}) - 10'(EXP_BIAS);
        c2_d = CLS_NORM;
        if (ca1_q[0] || cb1_q[0] || (ca1_q[1] && cb1_q[2]) || (ca1_q[2] && cb1_q[1]))
            c2_d = CLS_NAN;
        else if (ca1_q[1] || cb1_q[1])
            c2_d = CLS_INF;
        else if (ca1_q[2] || cb1_q[2])
            c2_d = CLS_ZERO;
    end

    mant_mul_24 u_mant_mul (
        .clk (clk),
        .rst (rst),
        .a_i (ma2_q),
        .b_i (mb2_q),
        .p_o (prod)
    );

    always_comb begin
        if (prod[47]) begin
            m5_d = prod[47:24];
            disc = prod[23:0];
            e5_d = e4_q + 10'sd1;
        end else begin
            m5_d = prod[46:23];
            disc = {prod[22:0], 1'b0};
            e5_d = e4_q;
        end
        grs5_d = {disc[23], disc[22], |disc[21:0]};
    end

    logic              inc;
    logic [24:0]       mant_r;
    logic [22:0]       frac_r;
    logic signed [9:0] exp_r;

`ifdef FLOAT_MUL_RNE_EN
    assign inc = grs5_q[2] & (grs5_q[1] | grs5_q[0] | m5_q[0]);
`else
    logic grs_unused;
    assign grs_unused = ^grs5_q;
    assign inc = 1'b0;
`endif

    always_comb begin
        mant_r = {1'b0, m5_q} + {24'b0, inc};
        frac_r = mant_r[22:0];
        exp_r  = e5_q;
        if (mant_r[24]) begin
            frac_r = mant_r[23:1];
            exp_r  = e5_q + 10'sd1;
        end
        out_d = {s5_q, exp_r[7:0], frac_r};
        case (c5_q)
            CLS_NAN:  out_d = QNAN;
            CLS_INF:  out_d = {s5_q, 8'hFF, 23'b0};
            CLS_ZERO: out_d = {s5_q, 31'b0};
            default: begin
                if (exp_r >= 10'(EXP_MAX))  out_d = {s5_q, 8'hFF, 23'b0};
                else if (exp_r <= 10'sd0)   out_d = {s5_q, 31'b0};
            end
        endcase
    end

    assign ack = ack_q;
    assign out = out_q;

endmodule

// File: tb/tb_float_mul_pipeline.sv
// Directed-vector bench for float_mul_pipeline; expectations follow FLOAT_MUL_RNE_EN.
module tb_float_mul_pipeline;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req = 1'b0;
    logic [31:0] op_a = '0;
    logic [31:0] op_b = '0;
    logic        ack_w;
    logic [31:0] out_w;
    int          checks = 0;
    int          failures = 0;

    always #5 clk = ~clk;

    float_mul_pipeline dut (
        .clk (clk),
        .rst (rst),
        .req (req),
        .ack (ack_w),
        .a   (op_a),
        .b   (op_b),
        .out (out_w)
    );

`ifdef FLOAT_MUL_RNE_EN
    localparam logic [31:0] P4600 = 32'h458FC000;
`else
    localparam logic [31:0] P4600 = 32'h458FBFFF;
`endif
    localparam logic [31:0] N4600 = P4600 | 32'h80000000;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp_v);
        checks++;
        if (got !== exp_v) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp_v);
        end
    endtask

    // Issue one operation, scramble operands while busy, watch 8 cycles for the ack.
    task automatic run_op(input logic [31:0] ta, input logic [31:0] tb_v,
                          input logic [31:0] ev, input string tag, input int hold);
        int lat, nack;
        @(negedge clk);
        op_a = ta;
        op_b = tb_v;
        req  = 1'b1;
        @(posedge clk);
        #1;
        if (hold == 0) req = 1'b0;
        op_a = 32'hDEADBEEF;
        op_b = 32'h12345678;
        lat  = 0;
        nack = 0;
        for (int k = 1; k <= 8; k++) begin
            @(posedge clk);
            #1;
            if (ack_w) begin
                nack++;
                if (lat == 0) lat = k;
            end
            if (k == hold) req = 1'b0;
        end
        chk({tag, "_lat"}, 32'(lat), 32'd6);
        chk({tag, "_nack"}, 32'(nack), 32'd1);
        chk(tag, out_w, ev);
    endtask

    initial begin
        int nack;
        repeat (2) @(negedge clk);
        chk("rst_out", out_w, 32'h0);
        chk("rst_ack", {31'b0, ack_w}, 32'h0);
        rst = 1'b1;

        run_op(32'h00000000, 32'h3F800000, 32'h00000000, "zero_x_one", 0);
        run_op(32'h3F800000, 32'h00000000, 32'h00000000, "one_x_zero", 0);
        run_op(32'h00000000, 32'h00000000, 32'h00000000, "zero_x_zero", 0);
        run_op(32'h3F800000, 32'h3F800000, 32'h3F800000, "one_x_one", 0);
        run_op(32'h40000000, 32'h40133333, 32'h40933333, "two_x_2p3", 0);
        run_op(32'h43480000, 32'h42C80000, 32'h469C4000, "200_x_100", 0);
        run_op(32'h3F8CCCCD, 32'h3F8CCCCD, 32'h3F9AE148, "1p1_sq", 0);
        run_op(32'hC4FA0000, 32'h40133333, N4600, "neg_x_pos", 0);
        run_op(32'h44FA0000, 32'hC0133333, N4600, "pos_x_neg", 0);
        run_op(32'hC4FA0000, 32'hC0133333, P4600, "neg_x_neg", 0);
        run_op(32'h40400000, 32'h3F000000, 32'h3FC00000, "hold_req", 5);
        run_op(32'h3FFFFFFF, 32'h3F800001, 32'h40000000, "norm_shift", 0);
        run_op(32'h7F000000, 32'h40800000, 32'h7F800000, "overflow", 0);
        run_op(32'h7F000000, 32'h3FFFFFFF, 32'h7F7FFFFF, "max_finite", 0);
        run_op(32'h7F800000, 32'h00000000, 32'h7FC00000, "inf_x_zero", 0);
        run_op(32'h7FC00001, 32'h3F800000, 32'h7FC00000, "nan_in", 0);
        run_op(32'hFF800000, 32'h40000000, 32'hFF800000, "ninf_x_two", 0);
        run_op(32'h80000000, 32'h40400000, 32'h80000000, "negzero", 0);
        run_op(32'h00400000, 32'h7F000000, 32'h00000000, "subnorm_in", 0);
        run_op(32'h0DA24260, 32'h0DA24260, 32'h00000000, "underflow", 0);
        run_op(32'h00800000, 32'h3F000000, 32'h00000000, "exp_zero_edge", 0);
        run_op(32'h00800000, 32'h3F800000, 32'h00800000, "min_normal", 0);

        // Abort an operation with reset at E0+3.
        @(negedge clk);
        op_a = 32'h40000000;
        op_b = 32'h40400000;
        req  = 1'b1;
        @(posedge clk);
        #1;
        req = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("rst_mid_out", out_w, 32'h0);
        @(negedge clk);
        rst  = 1'b1;
        nack = 0;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk);
            #1;
            if (ack_w) nack++;
        end
        chk("rst_mid_nack", 32'(nack), 32'd0);
        chk("rst_mid_out2", out_w, 32'h0);
        run_op(32'h40000000, 32'h40400000, 32'h40C00000, "after_rst", 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
